// File: rtl/seq_pulse_monitor_pkg.sv
// rtl/seq_pulse_monitor_pkg.sv - shared types and default sizes for the sequencer pulse monitor
package seq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    TIMEOUT_ST = 2'd3
  } monstate_t;

  localparam int SEQ_MON_CNT_W   = 8;
  localparam int SEQ_MON_PER_W   = 8;
  localparam int SEQ_MON_TIMEOUT = 16;

endpackage

// File: rtl/seq_pulse_monitor_if.sv
// rtl/seq_pulse_monitor_if.sv - control inputs and status outputs of the pulse monitor
interface seq_pulse_monitor_if
  import seq_mon_pkg::*;
#(
  parameter int CNT_W = SEQ_MON_CNT_W,
  parameter int PER_W = SEQ_MON_PER_W
);
  logic             en;
  logic             clr;
  logic             y_in;
  logic             edge_pulse;
  logic [CNT_W-1:0] pulse_count;
  logic [PER_W-1:0] last_period;
  logic             period_valid;
  logic             timeout;
  monstate_t        state_o;

  modport master (
    output en, clr, y_in,
    input  edge_pulse, pulse_count, last_period, period_valid, timeout, state_o
  );

  modport slave (
    input  en, clr, y_in,
    output edge_pulse, pulse_count, last_period, period_valid, timeout, state_o
  );
endinterface

// File: rtl/seq_pulse_monitor_sync_rise_detect.sv
// rtl/seq_pulse_monitor_sync_rise_detect.sv - two-flop sample of y with rising-edge output
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic y_q;
  logic y_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= 1'b0;
      y_p <= 1'b0;
    end else begin
      y_q <= d_i;
      y_p <= y_q;
    end
  end

  assign rise_o = y_q & ~y_p;
endmodule

// File: rtl/seq_pulse_monitor.sv
// rtl/seq_pulse_monitor.sv - counts home-state edges, measures their spacing, flags timeout
// PULSE_CNT_WRAP_EN: pulse_count wraps instead of saturating.
module seq_pulse_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W   = SEQ_MON_CNT_W,
  parameter int PER_W   = SEQ_MON_PER_W,
  parameter int TIMEOUT = SEQ_MON_TIMEOUT
) (
  input logic                clk,
  input logic                reset,
  seq_pulse_monitor_if.slave mon
);
  monstate_t        state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] last_period_q;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_inc;
  logic             timeout_q;
  logic             rise;
  logic             count_inc;
  logic             load_period;
  logic             set_timeout;

  sync_rise_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (mon.y_in),
    .rise_o (rise)
  );

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    count_inc   = 1'b0;
    load_period = 1'b0;
    set_timeout = 1'b0;
    if (!mon.en) begin
      state_d   = IDLE;
      per_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_FIRST;
        WAIT_FIRST, TIMEOUT_ST: begin
          // an edge after a timeout restarts timing but its interval is meaningless
          if (rise) begin
            count_inc = 1'b1;
            per_cnt_d = PER_W'(1);
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            count_inc   = 1'b1;
            load_period = 1'b1;
            per_cnt_d   = PER_W'(1);
          end else if (per_cnt_q == PER_W'(TIMEOUT)) begin
            set_timeout = 1'b1;
            state_d     = TIMEOUT_ST;
          end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PULSE_CNT_WRAP_EN
  assign pulse_count_inc = pulse_count_q + CNT_W'(1);
`else
  assign pulse_count_inc = (&pulse_count_q) ? pulse_count_q : pulse_count_q + CNT_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      per_cnt_q     <= '0;
      last_period_q <= '0;
      pulse_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      if (mon.clr) pulse_count_q <= '0;
      else if (count_inc) pulse_count_q <= pulse_count_inc;
      // a fresh measurement outranks clr so the strobe and value stay paired
      if (load_period) last_period_q <= per_cnt_q;
      else if (mon.clr) last_period_q <= '0;
      if (mon.clr) timeout_q <= 1'b0;
      else if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign mon.edge_pulse   = rise & (state_q != IDLE);
  assign mon.period_valid = load_period;
  assign mon.pulse_count  = pulse_count_q;
  assign mon.last_period  = last_period_q;
  assign mon.timeout      = timeout_q;
  assign mon.state_o      = state_q;
endmodule

// File: tb/tb_seq_pulse_monitor.sv
// tb/tb_seq_pulse_monitor.sv - randomized scoreboard bench for seq_pulse_monitor
module tb_seq_pulse_monitor;
  import seq_mon_pkg::*;

  localparam int CNT_W   = 8;
  localparam int PER_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_pulse_monitor_if #(.CNT_W(CNT_W), .PER_W(PER_W)) mon_if ();

  seq_pulse_monitor #(.CNT_W(CNT_W), .PER_W(PER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pv;
    int last;
    int cnt;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_err = 0;

  // reference model: time-stamped edges rather than a state register
  int cyc;
  bit m_armed, m_yq, m_yp, m_ref_ok, m_tmo, m_to;
  int m_ref, m_cnt, m_last;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_state();
    if (!m_armed) return int'(IDLE);
    if (!m_ref_ok) return int'(WAIT_FIRST);
    if (m_tmo) return int'(TIMEOUT_ST);
    return int'(MEASURE);
  endfunction

  function automatic int next_count(input int n);
`ifdef PULSE_CNT_WRAP_EN
    return (n + 1) % (CNT_MAX + 1);
`else
    return (n >= CNT_MAX) ? CNT_MAX : n + 1;
`endif
  endfunction

  task automatic model_reset();
    m_armed = 0; m_yq = 0; m_yp = 0; m_ref_ok = 0; m_tmo = 0; m_to = 0;
    m_ref = 0; m_cnt = 0; m_last = 0;
  endtask

  task automatic cycle(input bit e, input bit c, input bit y);
    bit rise, ep, act, pv;
    @(posedge clk);
    #1;
    chk("state_o", int'(mon_if.state_o), exp_state());
    chk("timeout", int'(mon_if.timeout), int'(m_to));
    chk("pulse_count", int'(mon_if.pulse_count), m_cnt);
    chk("last_period", int'(mon_if.last_period), m_last);
    mon_if.en = e; mon_if.clr = c; mon_if.y_in = y;
    rise = m_yq && !m_yp;
    ep   = m_armed && rise;
    act  = m_armed && e;
    pv   = act && rise && m_ref_ok && !m_tmo;
    if (act && rise) begin
      if (pv) m_last = cyc - m_ref;
      m_cnt = next_count(m_cnt);
      m_ref = cyc; m_ref_ok = 1; m_tmo = 0;
    end else if (act && m_ref_ok && !m_tmo && (cyc - m_ref) == TIMEOUT) begin
      m_to = 1; m_tmo = 1;
    end
    if (c) begin
      m_cnt = 0; m_to = 0;
      if (!pv) m_last = 0;
    end
    if (ep) sb.push_back('{pv: pv, last: m_last, cnt: m_cnt});
    if (!e) begin m_ref_ok = 0; m_tmo = 0; end
    m_armed = e; m_yp = m_yq; m_yq = y;
    cyc++;
  endtask

  task automatic pulse_train(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 1);
      repeat (per - 1) cycle(1, 0, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_edge_pulse"}, int'(mon_if.edge_pulse), 0);
    chk({tag, "_period_valid"}, int'(mon_if.period_valid), 0);
    chk({tag, "_pulse_count"}, int'(mon_if.pulse_count), 0);
    chk({tag, "_last_period"}, int'(mon_if.last_period), 0);
    chk({tag, "_timeout"}, int'(mon_if.timeout), 0);
    chk({tag, "_state"}, int'(mon_if.state_o), int'(IDLE));
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b1;
    mon_if.en = 0; mon_if.clr = 0; mon_if.y_in = 0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // monitor: pops one expected event per observed edge strobe
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && (mon_if.edge_pulse || mon_if.period_valid)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: edge_pulse=%0b period_valid=%0b with nothing expected at %0t",
                   mon_if.edge_pulse, mon_if.period_valid, $time);
        end else begin
          e = sb.pop_front();
          chk("ev_edge_pulse", int'(mon_if.edge_pulse), 1);
          chk("ev_period_valid", int'(mon_if.period_valid), int'(e.pv));
          @(posedge clk);
          #1;
          chk("ev_last_period", int'(mon_if.last_period), e.last);
          chk("ev_pulse_count", int'(mon_if.pulse_count), e.cnt);
        end
      end
    end
  end

  initial begin
    int hi, lo;
    mon_if.en = 0; mon_if.clr = 0; mon_if.y_in = 0;
    cyc = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    #10;
    reset = 1'b0;

    // periodic edges, interval 5
    pulse_train(12, 5);
    // reset in the middle of a measurement, then resume
    pulse_train(2, 5);
    reset_mid();
    pulse_train(4, 5);
    // interval at the limit, then one past it
    pulse_train(3, TIMEOUT);
    pulse_train(3, TIMEOUT + 1);
    pulse_train(3, 4);
    // y held high produces one edge; enabling while high produces none
    repeat (20) cycle(1, 0, 1);
    repeat (4) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 1);
    repeat (5) cycle(1, 0, 1);
    repeat (4) cycle(1, 0, 0);
    // clr coincident with a measured edge, then disable for 3 cycles
    pulse_train(3, 6);
    cycle(1, 0, 1);
    cycle(1, 1, 0);
    repeat (4) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    // 300 edges from a cleared count
    cycle(1, 1, 0);
    pulse_train(300, 3);
    @(negedge clk);
`ifdef PULSE_CNT_WRAP_EN
    chk("count_300_edges", int'(mon_if.pulse_count), 44);
`else
    chk("count_300_edges", int'(mon_if.pulse_count), 255);
`endif
    // random bursts with occasional disable and clr
    for (int s = 0; s < 60; s++) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 22);
      repeat (hi) cycle($urandom_range(0, 24) != 0, $urandom_range(0, 39) == 0, 1);
      repeat (lo) cycle($urandom_range(0, 24) != 0, $urandom_range(0, 39) == 0, 0);
    end
    repeat (3) cycle(1, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/seq_pulse_monitor.md
Name: seq_pulse_monitor

Overview:
Downstream consumer of the 3-bit sequencer's single-bit decode output y (high while the sequencer sits in its home state).
- Detects rising edges of y and counts them.
- Measures the interval between consecutive edges in clock cycles.
- Flags a sticky timeout when the sequence stops returning home within a bound.
- Feeds status/debug logic alongside the sequencer in the same clock domain.

Parameters:
CNT_W, 8, width of pulse_count
PER_W, 8, width of period counter and last_period
TIMEOUT, 16, max cycles between edges before timeout; legal range 2 .. 2**PER_W-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  monitor enable; level
clr  input  1  synchronous clear of pulse_count, last_period, timeout
y_in  input  1  sequencer home-state decode
edge_pulse  output  1  one-cycle strobe per detected rising edge of y_in
pulse_count  output  CNT_W  number of rising edges counted while enabled
last_period  output  PER_W  cycles between the two most recent valid edges
period_valid  output  1  one-cycle strobe when last_period updates
timeout  output  1  sticky; set when no edge arrives within TIMEOUT cycles
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset is reset, asynchronous, active-high; clock is clk. Everything else is synchronous.
- Reset values:
  - All registers and outputs 0.
  - FSM in IDLE.
  - Reset asserted mid-operation aborts any measurement immediately.
- Input path and edge detect:
  - y_q <= y_in; y_p <= y_q; rise = y_q & ~y_p.
  - edge_pulse = rise & (state != IDLE).
  - Latency: y_in sampled high at edge k gives edge_pulse high in the cycle after edge k. Counters and state update at edge k+1.
  - y held high produces exactly one rise.
  - The sync registers run in every state, including IDLE, so enabling while y is high does not create a false edge.
- FSM (monstate_t):
  - IDLE: no counting. Go to WAIT_FIRST when en=1.
  - WAIT_FIRST: on rise, count it, set per_cnt <= 1, go to MEASURE. No period_valid.
  - MEASURE:
    - On rise: last_period <= per_cnt, period_valid=1 for 1 cycle, per_cnt <= 1, count the edge.
    - With no rise and per_cnt == TIMEOUT: set timeout <= 1, go to TIMEOUT.
    - Otherwise: per_cnt++.
  - TIMEOUT: per_cnt frozen. On rise, count it, set per_cnt <= 1, go to MEASURE. No period_valid, because the interval is invalid.
  - en=0 in any state: next state IDLE and per_cnt <= 0. last_period, pulse_count and timeout are held.
- Period arithmetic:
  - The interval P between rises gives last_period = P.
  - P == TIMEOUT is legal. P == TIMEOUT+1 is a timeout.
  - per_cnt never exceeds TIMEOUT, so there is no overflow.
- pulse_count: +1 per edge_pulse; saturates at 2**CNT_W-1 (see optional feature).
- clr:
  - Zeros pulse_count, last_period and timeout.
  - Has priority over a same-cycle rise: pulse_count=0, and the edge is not counted.
  - Does not alter the FSM state or per_cnt, so period measurement continues.
  - period_valid still strobes if a rise occurs in MEASURE. last_period then takes the measured value, because the load has priority over clr for last_period only.
- Simultaneous rise and per_cnt==TIMEOUT in MEASURE: the rise wins. Period is recorded; no timeout.

Optional Feature:
PULSE_CNT_WRAP_EN
- Defined: pulse_count wraps modulo 2**CNT_W (255 -> 0).
- Undefined (default): pulse_count saturates at 2**CNT_W-1.
- No other behaviour changes.

Decomposition:
- Package seq_mon_pkg:
  - typedef enum logic [1:0] monstate_t {IDLE, WAIT_FIRST, MEASURE, TIMEOUT_ST}.
  - Default localparams for CNT_W, PER_W, TIMEOUT.
- Sub-module sync_rise_detect: two-flop sample plus rise output, reset to 0.
- Counters and FSM stay in seq_pulse_monitor.

Test Plan:
1. Reset mid-operation: en=1, pulses every 5 cycles, then reset asserted between clocks -> all outputs 0 immediately, state_o=IDLE. After release, first rise gives no period_valid.
2. Periodic y (period 5, high 1 cycle), en=1, TIMEOUT=16 -> first edge: pulse_count=1, no period_valid. Every later edge: period_valid with last_period=5; after 10 edges pulse_count=10, timeout=0.
3. Period exactly 16 -> last_period=16, timeout=0. Period 17 -> timeout=1 sticky, state TIMEOUT_ST. Next edge: state MEASURE, no period_valid, pulse_count still increments.
4. y_in held high 20 cycles -> exactly one edge_pulse. Assert en while y already high -> no edge_pulse.
5. clr coincident with rise -> pulse_count=0, timeout=0, last_period loads the measured value. en=0 for 3 cycles then 1 -> WAIT_FIRST, counts held.
6. 300 edges at period 3: without macro pulse_count=255; with PULSE_CNT_WRAP_EN pulse_count=44.
